multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle RV32I main control FSM: next generation of the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB, drives datapath muxes and enables per state.
//  Stalls on a shared instruction/data memory via mem_ready.
//  Counts retired instructions, traps illegal opcodes and memory timeouts.
// PARAMETERS
//  CNT_W        32  width of instret counter (wraps modulo 2^CNT_W)
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready before bus error; 0 = wait forever
//  TRAP_EN      1   1: illegal opcode -> TRAP; 0: illegal opcode treated as NOP (-> FETCH)
//  UPPER_EN     1   1: LUI/AUIPC supported; 0: they are illegal
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   7      IR[6:0], stable from DECODE onward
//  mem_ready    in   1      memory completes the current read/write this cycle
//  pc_write     out  1      PC <= result
//  adr_src      out  1      0 = PC, 1 = result (data address)
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  ir_write     out  1      IR/oldPC load
//  branch       out  1      PC update if ALU zero (datapath gates)
//  reg_write    out  1      register file write
//  alu_src_a    out  2      00 PC, 01 oldPC, 10 rs1, 11 zero
//  alu_src_b    out  2      00 rs2, 01 imm, 10 const 4
//  alu_op       out  2      00 add, 01 sub/compare, 10 funct-decoded
//  result_src   out  2      00 ALUOut reg, 01 mem data, 10 ALU result direct
//  illegal      out  1      sticky: illegal opcode trapped
//  bus_err      out  1      sticky: mem_ready timeout trapped
//  instret      out  CNT_W  retired-instruction count
//  state        out  4      current state encoding (debug)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=FETCH; illegal, bus_err, instret, wait counter = 0;
//   all control outputs forced 0 while rst_n low. First FETCH outputs appear after release.
//  Outputs are Moore (decoded from state) except pc_write/ir_write in FETCH (gated by mem_ready).
//   Unlisted outputs are 0.
//  State encodings / outputs / next state:
//   0 FETCH: mem_read, adr_src=0, a=00, b=10, op=00, res=10.
//     mem_ready=1 -> ir_write=1, pc_write=1, -> DECODE; otherwise stay.
//   1 DECODE: a=01, b=01, op=00.
//     Next by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//     1100011 -> BRANCH; 1101111 -> JAL; 0110111/0010111 -> UPPER (if UPPER_EN).
//     Any other opcode -> TRAP if TRAP_EN, else FETCH (counted as retired).
//   2 MEMADR: a=10, b=01, op=00. Load -> MEMREAD; store -> MEMWRITE.
//   3 MEMREAD: mem_read, adr_src=1. Stay until mem_ready -> MEMWB.
//   4 MEMWB: res=01, reg_write -> FETCH.
//   5 MEMWRITE: mem_write, adr_src=1. Stay until mem_ready -> FETCH.
//   6 EXECR: a=10, b=00, op=10 -> ALUWB.
//   7 EXECI: a=10, b=01, op=10 -> ALUWB.
//   8 ALUWB: res=00, reg_write -> FETCH.
//   9 BRANCH: a=10, b=00, op=01, res=00, branch -> FETCH.
//   10 JAL: a=01, b=10, op=00, res=00, pc_write -> ALUWB.
//     Writes rd = oldPC+4; target comes from ALUOut computed in DECODE.
//   11 UPPER: a=11 (LUI) or 01 (AUIPC), b=01, op=00 -> ALUWB.
//   12 TRAP: all enables 0; absorbing until reset.
//  instret += 1 on every transition into FETCH from a state other than FETCH/TRAP.
//   Wraps to 0 from all-ones.
//  Wait counter: cleared on entry to FETCH/MEMREAD/MEMWRITE; increments each cycle there
//   with mem_ready=0.
//   If MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP, bus_err=1.
//   mem_ready=1 in that same cycle wins (normal transition).
//  illegal/bus_err set on entry to TRAP; cleared only by reset.
//   Reset mid-operation aborts with no partial write held.
//  Unused encodings 13-15 -> FETCH next cycle, outputs 0.
// TESTING
//  R-type (0110011), mem_ready=1 -> states 0,1,6,8,0; reg_write only in state 8; instret 0->1.
//  Load (0000011), mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0;
//   res=01 in state 4.
//  Store (0100011), mem_ready=1 -> states 0,1,2,5,0; mem_write=1 one cycle; reg_write never 1.
//  Illegal opcode 1111111, TRAP_EN=1 -> state 12, illegal=1, instret unchanged.
//   With TRAP_EN=0 -> FETCH, instret +1.
//  MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, bus_err=1.
//  rst_n pulsed low in MEMREAD -> outputs 0 immediately; FETCH with mem_read=1 after release.
//  JAL -> pc_write in state 10, reg_write in 8.
//  CNT_W=2, 4 R-types -> instret wraps 3->0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on a shared memory, counts retired instructions and traps illegal ops / bus timeouts.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_EN     = 1'b1,
  parameter bit UPPER_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             branch,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_UPPER    = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;
  logic              r_illegal;
  logic              r_bus_err;
  logic              w_is_wait;
  logic              w_timeout;
  logic              w_retire;

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  // The last permitted wait cycle times out unless mem_ready arrives in it.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_is_wait && !mem_ready &&
                     (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
  assign w_retire  = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_is_wait && !mem_ready && (MEM_TIMEOUT != 0)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        if (w_timeout) begin
          r_bus_err <= 1'b1;
        end else begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_LUI, OP_AUIPC:  w_next = UPPER_EN ? S_UPPER : (TRAP_EN ? S_TRAP : S_FETCH);
          default:           w_next = TRAP_EN ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_UPPER:    w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next = S_TRAP;
    end
  end

  // Control outputs are held low for as long as reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          branch    = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_UPPER: begin
          alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
          alu_src_b = 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign instret = r_instret;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle state, control vector and
// instret are queued with the stimulus and compared as the FSM walks each instruction.
module tb_multicycle_control;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready;
  logic [6:0] opcode;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, branch, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       illegal, bus_err;
  logic [1:0] instret;
  logic [3:0] state;

  logic        b_rst_n, b_mem_ready;
  logic [6:0]  b_opcode;
  logic        b_pc_write, b_adr_src, b_mem_read, b_mem_write, b_ir_write, b_branch, b_reg_write;
  logic [1:0]  b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src;
  logic        b_illegal, b_bus_err;
  logic [31:0] b_instret;
  logic [3:0]  b_state;

  multicycle_control #(.CNT_W(2), .MEM_TIMEOUT(4), .TRAP_EN(1'b1), .UPPER_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .branch(branch), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .illegal(illegal), .bus_err(bus_err), .instret(instret), .state(state)
  );

  multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(0), .TRAP_EN(1'b0), .UPPER_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .opcode(b_opcode), .mem_ready(b_mem_ready),
    .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .branch(b_branch), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .result_src(b_result_src),
    .illegal(b_illegal), .bus_err(b_bus_err), .instret(b_instret), .state(b_state)
  );

  logic [14:0] ctrl, b_ctrl;
  assign ctrl   = {pc_write, ir_write, mem_read, mem_write, reg_write, branch, adr_src,
                   alu_src_a, alu_src_b, alu_op, result_src};
  assign b_ctrl = {b_pc_write, b_ir_write, b_mem_read, b_mem_write, b_reg_write, b_branch, b_adr_src,
                   b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src};

  typedef struct {
    logic [6:0]  opc;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [6:0]  cur_op = OP_R;

  // Control vector each state must present, taken from the state/output table.
  function automatic logic [14:0] ctrl_of(input logic [3:0] st, input logic rdy, input logic lui);
    logic pw, iw, mr, mw, rw, br, adr;
    logic [1:0] a, b, op, res;
    {pw, iw, mr, mw, rw, br, adr} = 7'b0;
    a = 2'b00; b = 2'b00; op = 2'b00; res = 2'b00;
    case (st)
      4'd0:  begin mr = 1'b1; b = 2'b10; res = 2'b10; pw = rdy; iw = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin mr = 1'b1; adr = 1'b1; end
      4'd4:  begin res = 2'b01; rw = 1'b1; end
      4'd5:  begin mw = 1'b1; adr = 1'b1; end
      4'd6:  begin a = 2'b10; op = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd8:  rw = 1'b1;
      4'd9:  begin a = 2'b10; op = 2'b01; br = 1'b1; end
      4'd10: begin a = 2'b01; b = 2'b10; pw = 1'b1; end
      4'd11: begin a = lui ? 2'b11 : 2'b01; b = 2'b01; end
      default: ;
    endcase
    return {pw, iw, mr, mw, rw, br, adr, a, b, op, res};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    exp_t e;
    e.opc  = cur_op;
    e.rdy  = rdy;
    e.st   = st;
    e.ctrl = ctrl_of(st, rdy, cur_op == OP_LUI);
    e.ret  = exp_ret;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b_rst_n = 1'b0;
    mem_ready = 1'b1; b_mem_ready = 1'b1;
    opcode = OP_R; b_opcode = OP_R;
    #12;
    n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (ctrl !== 15'd0) begin n_errors++; $display("FAIL reset_ctrl: got %b want 0", ctrl); end
    n_checks++; if (instret !== 2'd0) begin n_errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
    n_checks++; if ({illegal, bus_err} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b want 00", {illegal, bus_err}); end
    n_checks++; if (b_ctrl !== 15'd0) begin n_errors++; $display("FAIL reset_b_ctrl: got %b want 0", b_ctrl); end
    mem_ready = 1'b0; b_mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_instr(input string name);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      opcode = e.opc; mem_ready = e.rdy;
      #1;
      n_checks++; if (state !== e.st) begin n_errors++; $display("FAIL %s state: got %0d want %0d", name, state, e.st); end
      n_checks++; if (ctrl !== e.ctrl) begin n_errors++; $display("FAIL %s ctrl st%0d: got %b want %b", name, e.st, ctrl, e.ctrl); end
      n_checks++; if (instret !== e.ret[1:0]) begin n_errors++; $display("FAIL %s instret: got %0d want %0d", name, instret, e.ret[1:0]); end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    cur_op = OP_R;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd8, 1'b0); exp_ret++;
    test_instr("rtype");
  endtask

  task automatic test_load();
    cur_op = OP_LOAD;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd2, 1'b0);
    push(4'd3, 1'b0); push(4'd3, 1'b0); push(4'd3, 1'b1); push(4'd4, 1'b0); exp_ret++;
    test_instr("load");
  endtask

  task automatic test_store();
    cur_op = OP_STORE;
    // Ready arrives in the last permitted fetch wait cycle and must win over the timeout.
    push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b1);
    push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd5, 1'b1); exp_ret++;
    test_instr("store");
  endtask

  task automatic test_jal_upper();
    cur_op = OP_JAL;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd10, 1'b0); push(4'd8, 1'b0); exp_ret++;
    cur_op = OP_LUI;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd11, 1'b0); push(4'd8, 1'b0); exp_ret++;
    cur_op = OP_AUIPC;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd11, 1'b0); push(4'd8, 1'b0); exp_ret++;
    cur_op = OP_I;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd7, 1'b0); push(4'd8, 1'b0); exp_ret++;
    cur_op = OP_BRANCH;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd9, 1'b0); exp_ret++;
    test_instr("jal_upper");
  endtask

  task automatic test_back_to_back();
    cur_op = OP_R;
    for (int k = 0; k < 4; k++) begin
      push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd8, 1'b0); exp_ret++;
    end
    push(4'd0, 1'b0);
    test_instr("wrap");
  endtask

  task automatic test_reset_midop();
    cur_op = OP_LOAD;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0);
    test_instr("midop_pre");
    n_checks++; if (state !== 4'd3) begin n_errors++; $display("FAIL midop_memread: got %0d want 3", state); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL midop_state: got %0d want 0", state); end
    n_checks++; if (ctrl !== 15'd0) begin n_errors++; $display("FAIL midop_ctrl: got %b want 0", ctrl); end
    n_checks++; if (instret !== 2'd0) begin n_errors++; $display("FAIL midop_instret: got %0d want 0", instret); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 32'd0;
    cur_op = OP_R;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd8, 1'b0); exp_ret++;
    test_instr("midop_post");
  endtask

  task automatic test_illegal();
    cur_op = OP_BAD;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd12, 1'b0); push(4'd12, 1'b1); push(4'd12, 1'b0);
    test_instr("illegal");
    n_checks++; if ({illegal, bus_err} !== 2'b10) begin n_errors++; $display("FAIL illegal_flags: got %b want 10", {illegal, bus_err}); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 32'd0;
    #1;
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL illegal_clear: got %b want 0", illegal); end
  endtask

  task automatic test_timeout();
    cur_op = OP_R;
    push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b0);
    push(4'd12, 1'b0); push(4'd12, 1'b1);
    test_instr("timeout");
    n_checks++; if ({illegal, bus_err} !== 2'b01) begin n_errors++; $display("FAIL timeout_flags: got %b want 01", {illegal, bus_err}); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_trap_disabled();
    exp_t e;
    exp_ret = 32'd0;
    cur_op = OP_BAD; push(4'd0, 1'b1); push(4'd1, 1'b0); exp_ret++;
    cur_op = OP_LUI; push(4'd0, 1'b1); push(4'd1, 1'b0); exp_ret++;
    cur_op = OP_R;   push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd8, 1'b0); exp_ret++;
    for (int k = 0; k < 20; k++) push(4'd0, 1'b0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      b_opcode = e.opc; b_mem_ready = e.rdy;
      #1;
      n_checks++; if (b_state !== e.st) begin n_errors++; $display("FAIL notrap state: got %0d want %0d", b_state, e.st); end
      n_checks++; if (b_ctrl !== e.ctrl) begin n_errors++; $display("FAIL notrap ctrl st%0d: got %b want %b", e.st, b_ctrl, e.ctrl); end
      n_checks++; if (b_instret !== e.ret) begin n_errors++; $display("FAIL notrap instret: got %0d want %0d", b_instret, e.ret); end
      @(negedge clk);
    end
    n_checks++; if ({b_illegal, b_bus_err} !== 2'b00) begin n_errors++; $display("FAIL notrap_flags: got %b want 00", {b_illegal, b_bus_err}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_jal_upper();
    test_back_to_back();
    test_reset_midop();
    test_illegal();
    test_timeout();
    test_trap_disabled();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
